// File: rtl/imul_arb_pkg.sv
// Shared definitions for the two-port integer multiply arbiter.
//   - request message field positions ({a, b} packed into 2*P_NBITS bits)
//   - FSM state encoding
//   - port identifier type
package imul_arb_pkg;

    localparam int P_NBITS   = 32;

    // Request message layout: a in the upper half, b in the lower half.
    localparam int MSG_A_MSB = 2*P_NBITS - 1;
    localparam int MSG_A_LSB = P_NBITS;
    localparam int MSG_B_MSB = P_NBITS - 1;
    localparam int MSG_B_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,   // no result held
        RESP = 1'b1    // result held in operand registers, owner in owner_reg
    } arb_state_e;

    typedef logic port_t;

    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/imul_int_mul_arb2_if.sv
// Bundle of the two request and two response val/rdy channels.
//
// Handshake: a transfer happens on a rising clk edge where both val and rdy
// are high. A producer may raise val at any time; msg is only meaningful
// while val is high. rdy may depend combinationally on val.
//
// Modports:
//   master - the client side (drives requests, consumes responses)
//   slave  - the arbiter side (accepts requests, produces responses)
interface imul_int_mul_arb2_if #(
    parameter int p_nbits = 32
);
    logic                   req0_val;
    logic                   req0_rdy;
    logic [2*p_nbits-1:0]   req0_msg;
    logic                   req1_val;
    logic                   req1_rdy;
    logic [2*p_nbits-1:0]   req1_msg;

    logic                   resp0_val;
    logic                   resp0_rdy;
    logic [p_nbits-1:0]     resp0_msg;
    logic                   resp1_val;
    logic                   resp1_rdy;
    logic [p_nbits-1:0]     resp1_msg;

    modport master (
        output req0_val, req0_msg, req1_val, req1_msg,
        input  req0_rdy, req1_rdy,
        input  resp0_val, resp0_msg, resp1_val, resp1_msg,
        output resp0_rdy, resp1_rdy
    );

    modport slave (
        input  req0_val, req0_msg, req1_val, req1_msg,
        output req0_rdy, req1_rdy,
        output resp0_val, resp0_msg, resp1_val, resp1_msg,
        input  resp0_rdy, resp1_rdy
    );

endinterface

// File: rtl/imul_rr_arb2.sv
// Combinational two-input round-robin grant.
//   val0, val1 : request valids
//   prio       : port that wins when both request
//   en         : grants are only allowed while en is high
//   grant[1:0] : one-hot (or zero) grant
//   next_prio  : priority to load if the grant is taken (the loser)
module imul_rr_arb2
    import imul_arb_pkg::*;
(
    input  logic       val0,
    input  logic       val1,
    input  port_t      prio,
    input  logic       en,
    output logic [1:0] grant,
    output port_t      next_prio
);

    always_comb begin
        grant     = 2'b00;
        next_prio = prio;
        if (en) begin
            if (val0 && (!val1 || prio == PORT0)) begin
                grant[0] = 1'b1;
            end else if (val1) begin
                grant[1] = 1'b1;
            end
        end
        if (grant[0]) begin
            next_prio = PORT1;
        end else if (grant[1]) begin
            next_prio = PORT0;
        end
    end

endmodule

// File: rtl/imul_int_mul_arb2.sv
// Two-port round-robin arbiter in front of one registered 32-bit multiplier.
// Operands are captured on request fire; the truncated product is presented
// to the owning port the following cycle and held until it is consumed.
//
// Ports:
//   clk       : clock, all state updates on posedge
//   reset     : synchronous, active-high
//   bus       : slave side of imul_int_mul_arb2_if (2 req + 2 resp channels)
//   dbg_state : current FSM state, for observation only
module imul_int_mul_arb2
    import imul_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    imul_int_mul_arb2_if.slave   bus,
    output arb_state_e           dbg_state
);

    arb_state_e          state;
    port_t               owner_reg;
    port_t               prio_reg;
    port_t               next_prio;
    logic [P_NBITS-1:0]  op_a_reg;
    logic [P_NBITS-1:0]  op_b_reg;
    logic [P_NBITS-1:0]  product;
    logic [1:0]          grant;
    logic                resp_fire;
    logic                can_issue;
    logic                issue_en;
    logic                req_fire;

    // Only the owner's response ready counts; the other port's rdy is ignored.
    assign resp_fire = (state == RESP) &&
                       ((owner_reg == PORT1) ? bus.resp1_rdy : bus.resp0_rdy);

    // A new request may enter when the operand registers are free now or
    // are being freed at this very edge.
    assign can_issue = (state == IDLE) || resp_fire;
    assign issue_en  = can_issue && !reset;

    imul_rr_arb2 u_rr_arb2 (
        .val0      (bus.req0_val),
        .val1      (bus.req1_val),
        .prio      (prio_reg),
        .en        (issue_en),
        .grant     (grant),
        .next_prio (next_prio)
    );

    assign bus.req0_rdy = grant[0];
    assign bus.req1_rdy = grant[1];
    assign req_fire     = |grant;

    // Low half of the product; identical for signed and unsigned operands.
    assign product = op_a_reg * op_b_reg;

    assign bus.resp0_val = (state == RESP) && (owner_reg == PORT0);
    assign bus.resp1_val = (state == RESP) && (owner_reg == PORT1);
    assign bus.resp0_msg = product;
    assign bus.resp1_msg = product;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_reg <= PORT0;
            prio_reg  <= PORT0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
        end else if (req_fire) begin
            // Any pending response is consumed at this same edge.
            if (grant[1]) begin
                op_a_reg  <= bus.req1_msg[MSG_A_MSB:MSG_A_LSB];
                op_b_reg  <= bus.req1_msg[MSG_B_MSB:MSG_B_LSB];
                owner_reg <= PORT1;
            end else begin
                op_a_reg  <= bus.req0_msg[MSG_A_MSB:MSG_A_LSB];
                op_b_reg  <= bus.req0_msg[MSG_B_MSB:MSG_B_LSB];
                owner_reg <= PORT0;
            end
            state    <= RESP;
            prio_reg <= next_prio;
        end else if (resp_fire) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_imul_int_mul_arb2.sv
// Self-checking bench for imul_int_mul_arb2: directed vectors, per-port
// expected-product queues, and a negedge monitor that pops on response fire.
module tb_imul_int_mul_arb2;
    import imul_arb_pkg::*;

    logic       clk;
    logic       reset;
    arb_state_e dbg_state;

    imul_int_mul_arb2_if #(.p_nbits(32)) bus ();

    imul_int_mul_arb2 dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        if (port == 0) begin
            bus.req0_val = 1'b1;
            bus.req0_msg = {a, b};
            exp0_q.push_back(exp);
        end else begin
            bus.req1_val = 1'b1;
            bus.req1_msg = {a, b};
            exp1_q.push_back(exp);
        end
    endtask

    task automatic idle_req(input int port);
        if (port == 0) bus.req0_val = 1'b0;
        else           bus.req1_val = 1'b0;
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        bus.req0_val  = 1'b0;
        bus.req1_val  = 1'b0;
        bus.resp0_rdy = 1'b1;
        bus.resp1_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
    endtask

    function automatic logic [31:0] model_mul(input logic [63:0] msg);
        logic [31:0] a;
        logic [31:0] b;
        a = msg[63:32];
        b = msg[31:0];
        return a * b;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            n_cmp++;
            if (bus.resp0_val && bus.resp1_val) begin
                n_err++;
                $display("FAIL resp_val_onehot: got both high expected at most one");
            end
            n_cmp++;
            if (bus.req0_rdy && bus.req1_rdy) begin
                n_err++;
                $display("FAIL req_rdy_onehot: got both high expected at most one");
            end
            if (bus.resp0_val && bus.resp0_rdy) begin
                if (exp0_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL resp0_unexpected: got %h expected no response", bus.resp0_msg);
                end else begin
                    chk("resp0_msg", bus.resp0_msg, exp0_q.pop_front());
                end
            end
            if (bus.resp1_val && bus.resp1_rdy) begin
                if (exp1_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL resp1_unexpected: got %h expected no response", bus.resp1_msg);
                end else begin
                    chk("resp1_msg", bus.resp1_msg, exp1_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset         = 1'b1;
        bus.req0_val  = 1'b1;
        bus.req1_val  = 1'b1;
        bus.req0_msg  = {32'd3, 32'd5};
        bus.req1_msg  = {32'd3, 32'd5};
        bus.resp0_rdy = 1'b1;
        bus.resp1_rdy = 1'b1;

        // Reset values with requests pending: nothing may be granted.
        @(negedge clk);
        @(negedge clk);
        chk("rst_req0_rdy",   32'(bus.req0_rdy),  32'd0);
        chk("rst_req1_rdy",   32'(bus.req1_rdy),  32'd0);
        chk("rst_resp0_val",  32'(bus.resp0_val), 32'd0);
        chk("rst_resp1_val",  32'(bus.resp1_val), 32'd0);
        chk("rst_resp0_msg",  bus.resp0_msg,      32'd0);
        chk("rst_resp1_msg",  bus.resp1_msg,      32'd0);
        next_cycle();
        reset        = 1'b0;
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
        @(negedge clk);
        chk("idle_resp0_val", 32'(bus.resp0_val), 32'd0);
        chk("idle_resp1_val", 32'(bus.resp1_val), 32'd0);
        chk("idle_state",     32'(dbg_state),     32'(IDLE));

        // Single request on port 0: 3*5.
        next_cycle();
        issue(0, 32'd3, 32'd5, 32'd15);
        @(negedge clk);
        chk("t1_req0_rdy", 32'(bus.req0_rdy), 32'd1);
        next_cycle();
        idle_req(0);
        @(negedge clk);
        chk("t1_resp0_val", 32'(bus.resp0_val), 32'd1);
        chk("t1_resp1_val", 32'(bus.resp1_val), 32'd0);
        next_cycle();

        // Both request together from reset priority: port 0 then port 1.
        apply_reset();
        issue(0, 32'd7, 32'd6, 32'd42);
        issue(1, 32'd9, 32'd9, 32'd81);
        @(negedge clk);
        chk("t2_req0_rdy", 32'(bus.req0_rdy), 32'd1);
        chk("t2_req1_rdy", 32'(bus.req1_rdy), 32'd0);
        next_cycle();
        idle_req(0);
        @(negedge clk);
        chk("t2_req1_rdy_b", 32'(bus.req1_rdy),  32'd1);
        chk("t2_resp0_val",  32'(bus.resp0_val), 32'd1);
        next_cycle();
        idle_req(1);
        @(negedge clk);
        chk("t2_resp1_val", 32'(bus.resp1_val), 32'd1);
        next_cycle();

        // Port 1 response back-pressured for 3 cycles; port 0 stalls.
        bus.resp1_rdy = 1'b0;
        issue(1, 32'd4, 32'd4, 32'd16);
        @(negedge clk);
        chk("t3_req1_rdy", 32'(bus.req1_rdy), 32'd1);
        next_cycle();
        idle_req(1);
        issue(0, 32'd2, 32'd2, 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_resp1_val", 32'(bus.resp1_val), 32'd1);
            chk("t3_hold_resp1_msg", bus.resp1_msg,      32'd16);
            chk("t3_stall_req0_rdy", 32'(bus.req0_rdy),  32'd0);
            next_cycle();
        end
        bus.resp1_rdy = 1'b1;
        @(negedge clk);
        chk("t3_req0_rdy_on_fire", 32'(bus.req0_rdy), 32'd1);
        next_cycle();
        idle_req(0);
        @(negedge clk);
        chk("t3_resp0_val", 32'(bus.resp0_val), 32'd1);
        next_cycle();

        // Truncation corner cases.
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        chk("t4_req0_rdy", 32'(bus.req0_rdy), 32'd1);
        next_cycle();
        idle_req(0);
        @(negedge clk);
        next_cycle();
        issue(1, 32'h8000_0000, 32'd2, 32'h0000_0000);
        @(negedge clk);
        chk("t4_req1_rdy", 32'(bus.req1_rdy), 32'd1);
        next_cycle();
        idle_req(1);
        @(negedge clk);
        chk("t4_resp1_val", 32'(bus.resp1_val), 32'd1);
        next_cycle();

        // Continuous requests on both ports: grants alternate from port 0.
        apply_reset();
        bus.req0_val = 1'b1;
        bus.req1_val = 1'b1;
        bus.req0_msg = {$urandom(), $urandom()};
        bus.req1_msg = {$urandom(), $urandom()};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_req0_rdy", 32'(bus.req0_rdy), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t5_req1_rdy", 32'(bus.req1_rdy), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (bus.req0_rdy) exp0_q.push_back(model_mul(bus.req0_msg));
            if (bus.req1_rdy) exp1_q.push_back(model_mul(bus.req1_msg));
            next_cycle();
            if (i % 2 == 0) bus.req0_msg = {$urandom(), $urandom()};
            else            bus.req1_msg = {$urandom(), $urandom()};
        end
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
        @(negedge clk);
        next_cycle();

        // Reset while a result is held: result dropped, priority back to 0.
        bus.resp0_rdy = 1'b0;
        issue(0, 32'd3, 32'd3, 32'd9);
        @(negedge clk);
        chk("t6_req0_rdy", 32'(bus.req0_rdy), 32'd1);
        next_cycle();
        idle_req(0);
        @(negedge clk);
        chk("t6_held_resp0_val", 32'(bus.resp0_val), 32'd1);
        next_cycle();
        reset = 1'b1;
        exp0_q.delete();
        next_cycle();
        reset         = 1'b0;
        bus.resp0_rdy = 1'b1;
        issue(0, 32'd5, 32'd5, 32'd25);
        issue(1, 32'd6, 32'd6, 32'd36);
        @(negedge clk);
        chk("t6_resp0_val_dropped", 32'(bus.resp0_val), 32'd0);
        chk("t6_state_idle",        32'(dbg_state),     32'(IDLE));
        chk("t6_req0_rdy_first",    32'(bus.req0_rdy),  32'd1);
        chk("t6_req1_rdy_first",    32'(bus.req1_rdy),  32'd0);
        next_cycle();
        idle_req(0);
        @(negedge clk);
        chk("t6_req1_rdy_second", 32'(bus.req1_rdy), 32'd1);
        next_cycle();
        idle_req(1);
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("drain_exp0_q", 32'(exp0_q.size()), 32'd0);
        chk("drain_exp1_q", 32'(exp1_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
